// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver; define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_rx #(
    parameter int CLK_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

    localparam logic [15:0] LAST = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF = 16'((CLK_PER_BIT - 1) / 2);
`ifdef UART_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t      state, state_next;
    logic        rx_meta, rx_sync, armed;
    logic [1:0]  flush;
    logic [15:0] clk_count;
    logic [2:0]  bit_index;
    logic [7:0]  shift;
    logic        parity_err, bit_done, half_done, valid_next, err_next;

    assign bit_done  = clk_count == LAST;
    assign half_done = clk_count == HALF;

    // armed blocks a false start when reset releases into a line that is still low mid-frame
    always_ff @(posedge clk)
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            flush   <= 2'b00;
            armed   <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            flush   <= {flush[0], 1'b1};
            armed   <= armed | (flush[1] & rx_sync);
        end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (armed && !rx_sync) state_next = START;
            START:     if (half_done) state_next = rx_sync ? IDLE : DATA;
            DATA:      if (bit_done && bit_index == 3'd7) state_next = AFTER_DATA;
            PARITY:    if (bit_done) state_next = STOP;
            STOP:      if (bit_done) state_next = rx_sync ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_sync) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) begin
            clk_count <= '0;
            bit_index <= '0;
            shift     <= '0;
        end else begin
            clk_count <= (state == IDLE || state_next != state || bit_done) ? '0 : clk_count + 16'd1;
            if (state == DATA && bit_done) begin
                shift[bit_index] <= rx_sync;
                bit_index        <= bit_index + 3'd1;
            end
        end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk)
        if (rst)                            parity_err <= 1'b0;
        else if (state == PARITY && bit_done) parity_err <= rx_sync != ^shift;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        rx_busy    = state != IDLE;
        valid_next = state == STOP && bit_done && rx_sync && !parity_err;
        err_next   = state == STOP && bit_done && (!rx_sync || parity_err);
    end

    always_ff @(posedge clk)
        if (rst) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= valid_next;
            rx_frame_err <= err_next;
            if (valid_next) rx_data <= shift;
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven and randomized frames checked against a frame-level model of uart_rx.
module tb_uart_rx;
    localparam int CPB = 87;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    // edge where the start bit is driven -> result pulse: 3 sync/detect edges, half bit, full bits
    localparam int LAT = 3 + (CPB - 1) / 2 + 1 + (NBITS - 1) * CPB;

    logic       clk = 1'b0, rst = 1'b1, rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_frame_err, rx_busy;
    int         checks = 0, errors = 0, cyc = 0, overlap = 0;

    typedef struct { logic v; logic e; logic [7:0] d; int c; } ev_t;
    typedef struct {
        logic [7:0] data; logic stop; logic par; int stop_len; int gap; logic exp_v; logic [7:0] exp_d;
    } vec_t;
    ev_t ev_q[$];

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid || rx_frame_err) ev_q.push_back('{rx_valid, rx_frame_err, rx_data, cyc});
        if (rx_valid && rx_frame_err) overlap++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                              input int stop_len, input int rst_bit, output int start_cyc);
        logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
        bits = {stop, par, d, 1'b0};
`else
        bits = {par, stop, d, 1'b0};
`endif
        start_cyc = cyc;
        for (int b = 0; b < NBITS; b++) begin
            rx = bits[b];
            for (int k = 0; k < ((b == NBITS - 1) ? stop_len : CPB); k++) begin
                rst = (b == rst_bit && k == CPB / 2);
                @(negedge clk);
            end
        end
        rst = 1'b0;
    endtask

    task automatic run_frame(input string name, input logic [7:0] d, input logic stop, input logic par,
                             input int stop_len, input int gap, input logic exp_v, input logic [7:0] exp_d);
        int  sc;
        ev_t ev;
        send_frame(d, stop, par, stop_len, -1, sc);
        chk({name, "_events"}, ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            ev = ev_q.pop_front();
            chk({name, "_valid"}, ev.v, exp_v);
            chk({name, "_err"}, ev.e, !exp_v);
            chk({name, "_data"}, ev.d, exp_d);
            chk({name, "_cycle"}, ev.c, sc + LAT);
        end
        ev_q.delete();
        idle(gap);
        chk({name, "_hold"}, rx_data, exp_d);
    endtask

    initial begin
        vec_t       tv[9];
        logic [7:0] last_good, d;
        logic       stop, flip, ok;
        int         sc;
        tv[0] = '{8'hA5, 1'b1, 1'b0, CPB,  10, 1'b1, 8'hA5};
        tv[1] = '{8'h3C, 1'b0, 1'b0, 2000, 20, 1'b0, 8'hA5};
        tv[2] = '{8'h5A, 1'b1, 1'b0, CPB,  10, 1'b1, 8'h5A};
        tv[3] = '{8'h00, 1'b1, 1'b0, CPB,  0,  1'b1, 8'h00};
        tv[4] = '{8'hFF, 1'b1, 1'b0, CPB,  10, 1'b1, 8'hFF};
        tv[5] = '{8'h01, 1'b1, 1'b1, 50,   0,  1'b1, 8'h01};
        tv[6] = '{8'h80, 1'b1, 1'b1, 50,   10, 1'b1, 8'h80};
        tv[7] = '{8'hC3, 1'b0, 1'b0, CPB,  10, 1'b0, 8'h80};
        tv[8] = '{8'h7E, 1'b1, 1'b0, CPB,  20, 1'b1, 8'h7E};

        repeat (3) @(negedge clk);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_err", rx_frame_err, 1'b0);
        chk("reset_busy", rx_busy, 1'b0);
        rst = 1'b0;
        idle(10);

        for (int i = 0; i < 9; i++)
            run_frame($sformatf("vec%0d", i), tv[i].data, tv[i].stop, tv[i].par,
                      tv[i].stop_len, tv[i].gap, tv[i].exp_v, tv[i].exp_d);

        rx = 1'b0;
        repeat (10) @(negedge clk);
        chk("glitch_busy", rx_busy, 1'b1);
        repeat (10) @(negedge clk);
        idle(100);
        chk("glitch_events", ev_q.size(), 0);
        chk("glitch_idle", rx_busy, 1'b0);
        chk("glitch_data", rx_data, 8'h7E);

        send_frame(8'h81, 1'b1, 1'b0, CPB, 5, sc);
        idle(20);
        chk("rst_events", ev_q.size(), 0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_busy", rx_busy, 1'b0);
        ev_q.delete();
        run_frame("after_rst", 8'h42, 1'b1, 1'b0, CPB, 10, 1'b1, 8'h42);
        last_good = 8'h42;

`ifdef UART_RX_PARITY_EN
        run_frame("par_good", 8'h07, 1'b1, 1'b1, CPB, 10, 1'b1, 8'h07);
        run_frame("par_bad", 8'h07, 1'b1, 1'b0, CPB, 10, 1'b0, 8'h07);
        last_good = 8'h07;
`endif

        for (int i = 0; i < 20; i++) begin
            d    = 8'($urandom);
            stop = $urandom_range(0, 4) != 0;
            flip = NBITS == 11 && $urandom_range(0, 4) == 0;
            ok   = stop && !flip;
            if (ok) last_good = d;
            run_frame($sformatf("rand%0d", i), d, stop, ^d ^ flip,
                      stop ? int'($urandom_range(50, CPB)) : int'($urandom_range(CPB, 300)),
                      stop ? int'($urandom_range(0, 20)) : int'($urandom_range(5, 20)),
                      ok, last_good);
        end

        chk("overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_PER_BIT, default 87, clk cycles per bit (115200 baud at 10 MHz); legal range 4..65535.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rx  input  1  asynchronous serial line; idle high.
REQ-005 rx_data  output  8  last correctly received byte.
REQ-006 rx_valid  output  1  one-cycle pulse; rx_data updated on the same edge.
REQ-007 rx_frame_err  output  1  one-cycle pulse on a bad stop bit (or bad parity, REQ-027).
REQ-008 rx_busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 rx SHALL pass through a 2-flop synchronizer (rx_sync); both flops reset to 1; all decisions use rx_sync only.
REQ-010 Frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity unless REQ-027 applies.
REQ-011 States: IDLE, START, DATA, STOP, WAIT_HIGH; 16-bit clk_count; 3-bit bit_index.
REQ-012 IDLE: rx_sync==0 -> START with clk_count=0; otherwise stay in IDLE.
REQ-013 START: count up to (CLK_PER_BIT-1)/2 (43 at default); at that count, rx_sync==0 -> DATA with clk_count=0; rx_sync==1 -> IDLE (glitch rejected, no output pulse).
REQ-014 DATA: at clk_count==CLK_PER_BIT-1, shift rx_sync into bit[bit_index] and set clk_count=0; after bit 7 -> STOP, else bit_index+1.
REQ-015 STOP: at clk_count==CLK_PER_BIT-1, rx_sync==1 -> rx_data<=shift register, rx_valid=1 for exactly one cycle, -> IDLE.
REQ-016 STOP with rx_sync==0 -> rx_frame_err=1 for one cycle, rx_data unchanged, rx_valid stays 0, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rx_sync==1, then -> IDLE; a held-low break therefore yields exactly one rx_frame_err.
REQ-018 Latency: with E0 the edge at which IDLE samples rx_sync==0, rx_valid/rx_frame_err SHALL be high after edge E0+44+9*CLK_PER_BIT (E0+827 at default).
REQ-019 Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint SHALL be received with no byte lost.
REQ-020 rx_valid and rx_frame_err SHALL never be high in the same cycle.
REQ-021 rx_data SHALL hold its value between rx_valid pulses.
REQ-022 clk_count SHALL be zeroed on every state transition.

Reset
REQ-023 rst high on a clock edge -> state=IDLE, clk_count=0, bit_index=0, shift register=0, synchronizer flops=1.
REQ-024 Reset values: rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes at the next falling edge after rst deasserts.

Configuration
REQ-026 Macro UART_RX_PARITY_EN; without it the frame SHALL be exactly as in REQ-010.
REQ-027 With UART_RX_PARITY_EN: add state PARITY between DATA and STOP sampling one even-parity bit; mismatch -> at stop sample rx_frame_err pulse and no rx_valid (stop sample still taken); latency becomes E0+44+10*CLK_PER_BIT.

Verification
REQ-028 Default CLK_PER_BIT=87, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> one rx_valid pulse, rx_data=0xA5, rx_frame_err=0, pulse at REQ-018 timing.
REQ-029 rx low for 20 cycles, then high -> no rx_valid, no rx_frame_err, state back in IDLE, rx_busy low.
REQ-030 Send 0x3C with stop bit 0, line held low 2000 cycles -> exactly one rx_frame_err, rx_data keeps prior 0xA5, next 0x5A frame after line high received correctly.
REQ-031 Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses carrying 0x00 then 0xFF.
REQ-032 rst asserted one cycle during bit 4 of 0x81 -> no pulse, outputs at reset values; following 0x42 received correctly.
REQ-033 With UART_RX_PARITY_EN: 0x07 with parity 1 -> rx_valid, rx_data=0x07; 0x07 with parity 0 -> rx_frame_err only.
